// File: rtl/aes256_round_key_sequencer.sv
// Iterative AES-256 key expansion: takes one 256-bit key and streams RK0..RK14 over a valid/ready handshake.
// Optional macro ROUND_KEY_STORE_EN adds a 15-entry round-key bank with a combinational read port.
module aes256_round_key_sequencer #(
    parameter int NUM_RK = 15,
    parameter int IDX_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [255:0]     Key,
    input  logic             KeyValid,
    output logic             KeyReady,
    input  logic             Abort,
    output logic [127:0]     RoundKey,
    output logic [IDX_W-1:0] RkIndex,
    output logic             RkLast,
    output logic             RkValid,
    input  logic             RkReady,
    output logic             Busy,
    input  logic [IDX_W-1:0] RdIdx,
    output logic [127:0]     RdKey
);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t             state_q, state_d;
    logic [255:0]       win;
    logic [IDX_W-1:0]   rk_idx;
    logic [7:0]         rcon;
    logic               load, adv, at_last;
    logic [31:0]        sub_in, sub_out;
    logic [127:0]       even_half, odd_half;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (b^254) followed by the AES affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] sq, inv;
        sq  = b;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    assign at_last = (rk_idx == IDX_W'(NUM_RK - 1));

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        adv     = 1'b0;
        case (state_q)
            IDLE: begin
                if (KeyValid) begin
                    load    = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (RkReady) begin
                    adv = 1'b1;
                    if (at_last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (Abort) begin
            state_d = IDLE;
            load    = 1'b0;
            adv     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // One shared SubWord: odd steps build the next even half from RotWord(w7),
    // even steps build the odd half from the freshly written w3.
    assign sub_in  = rk_idx[0] ? {win[23:0], win[31:24]} : win[159:128];
    assign sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
                      sbox(sub_in[15:8]),  sbox(sub_in[7:0])};

    always_comb begin
        even_half[127:96] = sub_out ^ win[255:224] ^ {rcon, 24'h0};
        even_half[95:64]  = even_half[127:96] ^ win[223:192];
        even_half[63:32]  = even_half[95:64]  ^ win[191:160];
        even_half[31:0]   = even_half[63:32]  ^ win[159:128];
        odd_half[127:96]  = sub_out ^ win[127:96];
        odd_half[95:64]   = odd_half[127:96] ^ win[95:64];
        odd_half[63:32]   = odd_half[95:64]  ^ win[63:32];
        odd_half[31:0]    = odd_half[63:32]  ^ win[31:0];
    end

    // RK0's odd half comes straight from the key and RK14's is never needed.
    always_ff @(posedge clk) begin
        if (reset) begin
            win    <= '0;
            rk_idx <= '0;
            rcon   <= 8'h00;
        end else if (load) begin
            win    <= Key;
            rk_idx <= '0;
            rcon   <= 8'h01;
        end else if (adv) begin
            if (!at_last) rk_idx <= rk_idx + 1'b1;
            if (rk_idx[0]) begin
                win[255:128] <= even_half;
                rcon         <= xtime(rcon);
            end else if (rk_idx != '0 && !at_last) begin
                win[127:0] <= odd_half;
            end
        end
    end

    assign KeyReady = (state_q == IDLE);
    assign RkValid  = (state_q == STREAM);
    assign Busy     = (state_q != IDLE);
    assign RoundKey = rk_idx[0] ? win[127:0] : win[255:128];
    assign RkIndex  = rk_idx;
    assign RkLast   = at_last;

`ifdef ROUND_KEY_STORE_EN
    logic [127:0] bank [NUM_RK];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_RK; i++) bank[i] <= '0;
        end else if (adv) begin
            bank[rk_idx] <= RoundKey;
        end
    end

    assign RdKey = (RdIdx < IDX_W'(NUM_RK)) ? bank[RdIdx] : '0;
`else
    logic unused_rdidx;
    assign unused_rdidx = ^RdIdx;
    assign RdKey        = '0;
`endif

endmodule

// File: tb/tb_aes256_round_key_sequencer.sv
// Self-checking bench for aes256_round_key_sequencer: table-driven FIPS-197 key expansion model
// feeding a scoreboard queue, known-answer vectors, stalls, abort, mid-stream reset and the key store.
module tb_aes256_round_key_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] Key;
    logic         KeyValid;
    logic         KeyReady;
    logic         Abort;
    logic [127:0] RoundKey;
    logic [3:0]   RkIndex;
    logic         RkLast;
    logic         RkValid;
    logic         RkReady;
    logic         Busy;
    logic [3:0]   RdIdx;
    logic [127:0] RdKey;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [127:0] rk;
        logic [3:0]   idx;
    } exp_t;

    exp_t         sb[$];
    logic [127:0] model [15];
    logic [127:0] cap [15];

    localparam logic [255:0] KEY1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY2 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    aes256_round_key_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .Key      (Key),
        .KeyValid (KeyValid),
        .KeyReady (KeyReady),
        .Abort    (Abort),
        .RoundKey (RoundKey),
        .RkIndex  (RkIndex),
        .RkLast   (RkLast),
        .RkValid  (RkValid),
        .RkReady  (RkReady),
        .Busy     (Busy),
        .RdIdx    (RdIdx),
        .RdKey    (RdKey)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]};
    endfunction

    // Straight unrolled schedule: 60 words, result written to model[].
    function automatic void expand_key(input logic [255:0] k);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc_tab [7];
        rc_tab = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};
        for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0)      t = sub_word({t[23:0], t[31:24]}) ^ {rc_tab[i/8 - 1], 24'h0};
            else if (i % 8 == 4) t = sub_word(t);
            w[i] = w[i-8] ^ t;
        end
        for (int n = 0; n < 15; n++) model[n] = {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    endfunction

    // Loads k, then drives RkReady with readyPct% probability. When stopAt >= 0 the stream is
    // cut with Abort (or reset if useReset) on the cycle RK stopAt is handshaken.
    task automatic run_stream(input logic [255:0] k, input int readyPct, input int stopAt,
                              input bit useReset, input bit holdKv);
        exp_t         e;
        int           cycles;
        bit           done;
        bit           stalled;
        logic [127:0] prevKey;
        logic [3:0]   prevIdx;
        expand_key(k);
        for (int n = 0; n < 15; n++) cap[n] = '0;
        sb.delete();
        Key      = k;
        KeyValid = 1'b1;
        for (int n = 0; n < 15; n++) sb.push_back('{rk: model[n], idx: 4'(n)});
        @(posedge clk); #1;
        KeyValid = holdKv;
        Key      = holdKv ? ~k : '0;
        cycles   = 0;
        done     = 1'b0;
        stalled  = 1'b0;
        prevKey  = '0;
        prevIdx  = '0;
        while (!done && cycles < 400) begin
            RkReady = ($urandom_range(0, 99) < readyPct);
            if (stopAt >= 0 && sb.size() > 0 && sb[0].idx == 4'(stopAt)) begin
                RkReady = 1'b1;
                if (useReset) reset = 1'b1;
                else          Abort = 1'b1;
                @(posedge clk); #1;
                reset    = 1'b0;
                Abort    = 1'b0;
                RkReady  = 1'b0;
                KeyValid = 1'b0;
                @(negedge clk);
                total++;
                if (RkValid !== 1'b0 || KeyReady !== 1'b1 || Busy !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL stop_flags: got valid=%b ready=%b busy=%b want 0 1 0", RkValid, KeyReady, Busy);
                end
                if (useReset) begin
                    total++;
                    if (RoundKey !== 128'h0 || RkIndex !== 4'h0 || RkLast !== 1'b0 || RdKey !== 128'h0) begin
                        bad++;
                        $display("[TB] FAIL reset_outputs: got rk=%h idx=%0d last=%b rd=%h want all 0",
                                 RoundKey, RkIndex, RkLast, RdKey);
                    end
                end
                sb.delete();
                @(posedge clk); #1;
                return;
            end
            @(negedge clk);
            cycles++;
            total++;
            if (RkValid !== 1'b1) begin
                bad++;
                $display("[TB] FAIL valid_gap: got RkValid=%b want 1 at cycle %0d", RkValid, cycles);
            end
            if (stalled) begin
                total++;
                if (RoundKey !== prevKey || RkIndex !== prevIdx) begin
                    bad++;
                    $display("[TB] FAIL stall_hold: got %h/%0d want %h/%0d", RoundKey, RkIndex, prevKey, prevIdx);
                end
            end
            if (RkValid === 1'b1 && RkReady) begin
                stalled = 1'b0;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL extra_key: got idx=%0d want no more round keys", RkIndex);
                    done = 1'b1;
                end else begin
                    e = sb.pop_front();
                    if (RoundKey !== e.rk || RkIndex !== e.idx || RkLast !== (e.idx == 4'd14)) begin
                        bad++;
                        $display("[TB] FAIL round_key: got %h idx=%0d last=%b want %h idx=%0d last=%b",
                                 RoundKey, RkIndex, RkLast, e.rk, e.idx, (e.idx == 4'd14));
                    end
                    cap[e.idx] = RoundKey;
                    if (e.idx == 4'd14) done = 1'b1;
                end
            end else begin
                stalled = 1'b1;
                prevKey = RoundKey;
                prevIdx = RkIndex;
            end
            @(posedge clk); #1;
        end
        KeyValid = 1'b0;
        RkReady  = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("[TB] FAIL stream_timeout: got %0d keys left want 0", sb.size());
        end
        if (readyPct == 100) begin
            total++;
            if (cycles != 15) begin
                bad++;
                $display("[TB] FAIL throughput: got %0d cycles want 15", cycles);
            end
        end
        @(negedge clk);
        total++;
        if (KeyReady !== 1'b1 || RkValid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL end_idle: got ready=%b valid=%b want 1 0", KeyReady, RkValid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total++;
        if (KeyReady !== 1'b1 || RkValid !== 1'b0 || Busy !== 1'b0 || RkLast !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_flags: got ready=%b valid=%b busy=%b last=%b want 1 0 0 0",
                     KeyReady, RkValid, Busy, RkLast);
        end
        total++;
        if (RoundKey !== 128'h0 || RkIndex !== 4'h0 || RdKey !== 128'h0) begin
            bad++;
            $display("[TB] FAIL reset_data: got rk=%h idx=%0d rd=%h want 0", RoundKey, RkIndex, RdKey);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_known_vector();
        run_stream(KEY1, 100, -1, 1'b0, 1'b0);
        total++;
        if (cap[0] !== 128'h000102030405060708090a0b0c0d0e0f || cap[1] !== 128'h101112131415161718191a1b1c1d1e1f) begin
            bad++;
            $display("[TB] FAIL kat_rk01: got %h %h want key halves", cap[0], cap[1]);
        end
        total++;
        if (cap[2] !== 128'ha573c29fa176c498a97fce93a572c09c) begin
            bad++;
            $display("[TB] FAIL kat_rk2: got %h want a573c29fa176c498a97fce93a572c09c", cap[2]);
        end
        total++;
        if (cap[14] !== 128'h24fc79ccbf0979e9371ac23c6d68de36) begin
            bad++;
            $display("[TB] FAIL kat_rk14: got %h want 24fc79ccbf0979e9371ac23c6d68de36", cap[14]);
        end
    endtask

    task automatic test_round_key_store();
        logic [127:0] want;
        expand_key(KEY1);
        for (int i = 15; i >= 0; i--) begin
            RdIdx = 4'(i);
`ifdef ROUND_KEY_STORE_EN
            want = (i < 15) ? model[i] : 128'h0;
`else
            want = 128'h0;
`endif
            #1;
            total++;
            if (RdKey !== want) begin
                bad++;
                $display("[TB] FAIL store_read: idx=%0d got %h want %h", i, RdKey, want);
            end
        end
        RdIdx = 4'h0;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_key();
        run_stream(256'h0, 100, -1, 1'b0, 1'b0);
        total++;
        if (cap[2] !== 128'h62636363626363636263636362636363) begin
            bad++;
            $display("[TB] FAIL zero_rk2: got %h want 62636363626363636263636362636363", cap[2]);
        end
    endtask

    task automatic test_random_keys();
        logic [255:0] k;
        for (int i = 0; i < 200; i++) begin
            k = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
            run_stream(k, 100, -1, 1'b0, 1'b0);
        end
    endtask

    task automatic test_stalls();
        run_stream(KEY1, 50, -1, 1'b0, 1'b1);
        total++;
        if (cap[14] !== 128'h24fc79ccbf0979e9371ac23c6d68de36) begin
            bad++;
            $display("[TB] FAIL stall_rk14: got %h want 24fc79ccbf0979e9371ac23c6d68de36", cap[14]);
        end
    endtask

    task automatic test_abort();
        run_stream(KEY2, 60, 6, 1'b0, 1'b0);
        run_stream(KEY1, 100, -1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        run_stream(KEY2, 70, 9, 1'b1, 1'b0);
        run_stream(KEY2, 100, -1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_stream(KEY2, 100, -1, 1'b0, 1'b0);
        run_stream(KEY1, 100, -1, 1'b0, 1'b0);
    endtask

    initial begin
        reset    = 1'b1;
        Key      = '0;
        KeyValid = 1'b0;
        Abort    = 1'b0;
        RkReady  = 1'b0;
        RdIdx    = 4'h0;
        test_reset();
        test_known_vector();
        test_round_key_store();
        test_zero_key();
        test_random_keys();
        test_stalls();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
